// File: rtl/reservation_station_multi_if.sv
// -----------------------------------------------------------------------------
// reservation_station_multi_if
// Bundles every signal between the issue stage / CDB / ALU and the reservation
// station, except the clock and the asynchronous reset.
//   master : issue request, CDB snoop channels, ALU stall, rdy/clr controls
//            (driven by the surrounding pipeline); observes full/count/dispatch.
//   slave  : the reservation station itself.
// Ports:
//   rdy_in, clr_in                     global enable / synchronous flush
//   issue_*                            one decoded instruction per cycle
//   rs_full, rs_count                  occupancy report
//   cdb_valid/cdb_rob_index/cdb_result packed per-channel broadcasts
//   alu_stall_in                       ALU back-pressure
//   rs_to_alu_*                        registered dispatch payload
// -----------------------------------------------------------------------------
interface reservation_station_multi_if #(
  parameter int RS_DEPTH  = 16,
  parameter int CDB_CH    = 2,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int OP_W      = 6
) ();
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  logic                        rdy_in;
  logic                        clr_in;
  logic                        issue_valid;
  logic [ROB_IDX_W-1:0]        issue_rob_index;
  logic [OP_W-1:0]             issue_op;
  logic [DATA_W-1:0]           issue_imm;
  logic [ADDR_W-1:0]           issue_PC;
  logic [DATA_W-1:0]           issue_rs1_val;
  logic                        issue_rs1_busy;
  logic [ROB_IDX_W-1:0]        issue_rs1_depend;
  logic [DATA_W-1:0]           issue_rs2_val;
  logic                        issue_rs2_busy;
  logic [ROB_IDX_W-1:0]        issue_rs2_depend;
  logic                        rs_full;
  logic [CNT_W-1:0]            rs_count;
  logic [CDB_CH-1:0]           cdb_valid;
  logic [CDB_CH*ROB_IDX_W-1:0] cdb_rob_index;
  logic [CDB_CH*DATA_W-1:0]    cdb_result;
  logic                        alu_stall_in;
  logic                        rs_to_alu_ready;
  logic [OP_W-1:0]             rs_to_alu_op;
  logic [DATA_W-1:0]           rs_to_alu_rs1;
  logic [DATA_W-1:0]           rs_to_alu_rs2;
  logic [DATA_W-1:0]           rs_to_alu_imm;
  logic [ADDR_W-1:0]           rs_to_alu_PC;
  logic [ROB_IDX_W-1:0]        rs_to_alu_rob_index;

  modport master (
    output rdy_in, clr_in, issue_valid, issue_rob_index, issue_op, issue_imm,
           issue_PC, issue_rs1_val, issue_rs1_busy, issue_rs1_depend,
           issue_rs2_val, issue_rs2_busy, issue_rs2_depend,
           cdb_valid, cdb_rob_index, cdb_result, alu_stall_in,
    input  rs_full, rs_count, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1,
           rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index
  );

  modport slave (
    input  rdy_in, clr_in, issue_valid, issue_rob_index, issue_op, issue_imm,
           issue_PC, issue_rs1_val, issue_rs1_busy, issue_rs1_depend,
           issue_rs2_val, issue_rs2_busy, issue_rs2_depend,
           cdb_valid, cdb_rob_index, cdb_result, alu_stall_in,
    output rs_full, rs_count, rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1,
           rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index
  );
endinterface

// File: rtl/reservation_station_multi.sv
// -----------------------------------------------------------------------------
// reservation_station_multi
// Out-of-order reservation station: holds up to RS_DEPTH decoded instructions,
// snoops CDB_CH result channels to resolve operands, and dispatches the oldest
// fully-ready entry to the ALU once per cycle.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : reservation_station_multi_if.slave (issue, CDB, ALU, status)
// -----------------------------------------------------------------------------
module reservation_station_multi #(
  parameter int RS_DEPTH  = 16,
  parameter int CDB_CH    = 2,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int OP_W      = 6
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  reservation_station_multi_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_hit_t;

  // Returns the result of the lowest-numbered valid channel carrying tag dep.
  function automatic cdb_hit_t cdb_lookup(
    input logic [ROB_IDX_W-1:0]        dep,
    input logic [CDB_CH-1:0]           valid,
    input logic [CDB_CH*ROB_IDX_W-1:0] idx,
    input logic [CDB_CH*DATA_W-1:0]    res
  );
    cdb_hit_t r;
    r.hit  = 1'b0;
    r.data = {DATA_W{1'b0}};
    // Scan downwards so channel 0 overrides higher channels.
    for (int k = CDB_CH - 1; k >= 0; k--) begin
      if (valid[k] && (idx[k*ROB_IDX_W +: ROB_IDX_W] == dep)) begin
        r.hit  = 1'b1;
        r.data = res[k*DATA_W +: DATA_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Entry storage
  logic [RS_DEPTH-1:0]  r_busy;
  logic [RS_DEPTH-1:0]  r_p1;
  logic [RS_DEPTH-1:0]  r_p2;
  logic [OP_W-1:0]      r_op  [RS_DEPTH];
  logic [DATA_W-1:0]    r_imm [RS_DEPTH];
  logic [ADDR_W-1:0]    r_pc  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_rob [RS_DEPTH];
  logic [DATA_W-1:0]    r_v1  [RS_DEPTH];
  logic [DATA_W-1:0]    r_v2  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_d1  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_d2  [RS_DEPTH];
  // r_older[j][i] = 1 means entry j was issued before entry i.
  logic [RS_DEPTH-1:0]  r_older [RS_DEPTH];

  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_out_ready;
  logic [OP_W-1:0]      r_out_op;
  logic [DATA_W-1:0]    r_out_rs1;
  logic [DATA_W-1:0]    r_out_rs2;
  logic [DATA_W-1:0]    r_out_imm;
  logic [ADDR_W-1:0]    r_out_pc;
  logic [ROB_IDX_W-1:0] r_out_rob;

  logic [RS_DEPTH-1:0]  w_ready;
  logic [RS_DEPTH-1:0]  w_sel;
  logic [RS_DEPTH-1:0]  w_disp_oh;
  logic [RS_DEPTH-1:0]  w_issue_oh;
  logic [RS_DEPTH-1:0]  w_busy_nxt;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_has_free;
  logic                 w_do_disp;
  logic                 w_accept;
  logic [CNT_W-1:0]     w_count_nxt;
  cdb_hit_t             w_byp1;
  cdb_hit_t             w_byp2;
  cdb_hit_t             w_wake1 [RS_DEPTH];
  cdb_hit_t             w_wake2 [RS_DEPTH];

  // Oldest-ready selection through the age matrix, plus lowest free slot.
  always_comb begin
    w_ready    = r_busy & ~r_p1 & ~r_p2;
    w_sel      = {RS_DEPTH{1'b0}};
    w_sel_idx  = {IDX_W{1'b0}};
    w_free_idx = {IDX_W{1'b0}};
    for (int i = 0; i < RS_DEPTH; i++) begin
      logic v_blk;
      v_blk = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        v_blk = v_blk | (w_ready[j] & r_older[j][i]);
      end
      w_sel[i]  = w_ready[i] & ~v_blk;
      w_sel_idx = w_sel[i] ? IDX_W'(i) : w_sel_idx;
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      w_free_idx = r_busy[i] ? w_free_idx : IDX_W'(i);
    end
    w_has_free = ~(&r_busy);
    w_do_disp  = (|w_sel) & ~bus.alu_stall_in;
    w_accept   = bus.issue_valid & ~r_full & w_has_free;
  end

  // Next busy vector and its population count; freed slots are not reusable this cycle.
  always_comb begin
    w_count_nxt = {CNT_W{1'b0}};
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_disp_oh[i]  = w_do_disp & (w_sel_idx == IDX_W'(i));
      w_issue_oh[i] = w_accept & (w_free_idx == IDX_W'(i));
    end
    w_busy_nxt = (r_busy & ~w_disp_oh) | w_issue_oh;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_count_nxt = w_count_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  // CDB matches for the incoming instruction (bypass) and for stored entries (wakeup).
  always_comb begin
    w_byp1 = cdb_lookup(bus.issue_rs1_depend, bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
    w_byp2 = cdb_lookup(bus.issue_rs2_depend, bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_wake1[i] = cdb_lookup(r_d1[i], bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
      w_wake2[i] = cdb_lookup(r_d2[i], bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
    end
  end

  // Entry, age, occupancy and dispatch-payload state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy      <= {RS_DEPTH{1'b0}};
      r_p1        <= {RS_DEPTH{1'b0}};
      r_p2        <= {RS_DEPTH{1'b0}};
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_op[i]    <= {OP_W{1'b0}};
        r_imm[i]   <= {DATA_W{1'b0}};
        r_pc[i]    <= {ADDR_W{1'b0}};
        r_rob[i]   <= {ROB_IDX_W{1'b0}};
        r_v1[i]    <= {DATA_W{1'b0}};
        r_v2[i]    <= {DATA_W{1'b0}};
        r_d1[i]    <= {ROB_IDX_W{1'b0}};
        r_d2[i]    <= {ROB_IDX_W{1'b0}};
        r_older[i] <= {RS_DEPTH{1'b0}};
      end
      r_count     <= {CNT_W{1'b0}};
      r_full      <= 1'b0;
      r_out_ready <= 1'b0;
      r_out_op    <= {OP_W{1'b0}};
      r_out_rs1   <= {DATA_W{1'b0}};
      r_out_rs2   <= {DATA_W{1'b0}};
      r_out_imm   <= {DATA_W{1'b0}};
      r_out_pc    <= {ADDR_W{1'b0}};
      r_out_rob   <= {ROB_IDX_W{1'b0}};
    end else if (bus.clr_in) begin
      // Flush: payload registers keep their last values.
      r_busy      <= {RS_DEPTH{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_full      <= 1'b0;
      r_out_ready <= 1'b0;
    end else if (bus.rdy_in) begin
      r_busy      <= w_busy_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_W'(RS_DEPTH));
      r_out_ready <= w_do_disp;
      if (w_do_disp) begin
        r_out_op  <= r_op[w_sel_idx];
        r_out_rs1 <= r_v1[w_sel_idx];
        r_out_rs2 <= r_v2[w_sel_idx];
        r_out_imm <= r_imm[w_sel_idx];
        r_out_pc  <= r_pc[w_sel_idx];
        r_out_rob <= r_rob[w_sel_idx];
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_issue_oh[i]) begin
          r_op[i]    <= bus.issue_op;
          r_imm[i]   <= bus.issue_imm;
          r_pc[i]    <= bus.issue_PC;
          r_rob[i]   <= bus.issue_rob_index;
          r_d1[i]    <= bus.issue_rs1_depend;
          r_d2[i]    <= bus.issue_rs2_depend;
          r_p1[i]    <= bus.issue_rs1_busy & ~w_byp1.hit;
          r_p2[i]    <= bus.issue_rs2_busy & ~w_byp2.hit;
          r_v1[i]    <= (bus.issue_rs1_busy & w_byp1.hit) ? w_byp1.data : bus.issue_rs1_val;
          r_v2[i]    <= (bus.issue_rs2_busy & w_byp2.hit) ? w_byp2.data : bus.issue_rs2_val;
          // Newest entry: older than nobody.
          r_older[i] <= {RS_DEPTH{1'b0}};
        end else begin
          if (r_busy[i] && r_p1[i] && w_wake1[i].hit) begin
            r_v1[i] <= w_wake1[i].data;
            r_p1[i] <= 1'b0;
          end
          if (r_busy[i] && r_p2[i] && w_wake2[i].hit) begin
            r_v2[i] <= w_wake2[i].data;
            r_p2[i] <= 1'b0;
          end
          // Every other entry becomes older than the one being issued.
          if (w_accept) begin
            r_older[i][w_free_idx] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.rs_full             = r_full;
  assign bus.rs_count            = r_count;
  assign bus.rs_to_alu_ready     = r_out_ready;
  assign bus.rs_to_alu_op        = r_out_op;
  assign bus.rs_to_alu_rs1       = r_out_rs1;
  assign bus.rs_to_alu_rs2       = r_out_rs2;
  assign bus.rs_to_alu_imm       = r_out_imm;
  assign bus.rs_to_alu_PC        = r_out_pc;
  assign bus.rs_to_alu_rob_index = r_out_rob;
endmodule

// File: tb/tb_reservation_station_multi.sv
// -----------------------------------------------------------------------------
// tb_reservation_station_multi
// Scoreboard bench: the driver applies one stimulus per cycle and pushes the
// reference model's expected post-edge outputs into a queue; an independent
// monitor pops one expectation per cycle and compares it with the DUT.
// The model keeps the station as an age-ordered queue of instructions.
// -----------------------------------------------------------------------------
module tb_reservation_station_multi;
  localparam int RS_DEPTH  = 16;
  localparam int CDB_CH    = 2;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int OP_W      = 6;
  localparam int CNT_W     = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    bit                        rst;
    bit                        rdy;
    bit                        clr;
    bit                        iv;
    bit [ROB_IDX_W-1:0]        rob;
    bit [OP_W-1:0]             op;
    bit [DATA_W-1:0]           imm;
    bit [ADDR_W-1:0]           pc;
    bit [DATA_W-1:0]           v1;
    bit                        b1;
    bit [ROB_IDX_W-1:0]        d1;
    bit [DATA_W-1:0]           v2;
    bit                        b2;
    bit [ROB_IDX_W-1:0]        d2;
    bit [CDB_CH-1:0]           cv;
    bit [CDB_CH*ROB_IDX_W-1:0] cidx;
    bit [CDB_CH*DATA_W-1:0]    cres;
    bit                        stall;
  } stim_t;

  typedef struct packed {
    bit [ROB_IDX_W-1:0] rob;
    bit [OP_W-1:0]      op;
    bit [DATA_W-1:0]    imm;
    bit [ADDR_W-1:0]    pc;
    bit [DATA_W-1:0]    v1;
    bit                 p1;
    bit [ROB_IDX_W-1:0] d1;
    bit [DATA_W-1:0]    v2;
    bit                 p2;
    bit [ROB_IDX_W-1:0] d2;
  } ent_t;

  typedef struct packed {
    bit                 ready;
    bit [ROB_IDX_W-1:0] rob;
    bit [OP_W-1:0]      op;
    bit [DATA_W-1:0]    rs1;
    bit [DATA_W-1:0]    rs2;
    bit [DATA_W-1:0]    imm;
    bit [ADDR_W-1:0]    pc;
    bit [CNT_W-1:0]     count;
    bit                 full;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reservation_station_multi_if #(
    .RS_DEPTH(RS_DEPTH), .CDB_CH(CDB_CH), .ROB_IDX_W(ROB_IDX_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)
  ) bus ();

  reservation_station_multi #(
    .RS_DEPTH(RS_DEPTH), .CDB_CH(CDB_CH), .ROB_IDX_W(ROB_IDX_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  ent_t m_q[$];
  exp_t m_last;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Lowest valid channel carrying tag, or -1.
  function automatic int cdb_hit(input stim_t s, input bit [ROB_IDX_W-1:0] tag);
    for (int k = 0; k < CDB_CH; k++) begin
      if (s.cv[k] && (s.cidx[k*ROB_IDX_W +: ROB_IDX_W] == tag)) return k;
    end
    return -1;
  endfunction

  // Reference behaviour for one clock edge with stimulus s.
  task automatic model_step(input stim_t s);
    exp_t e;
    ent_t n;
    int   sel;
    int   k;
    int   n_before;
    e = m_last;
    if (s.rst) begin
      m_q.delete();
      e = '0;
    end else if (s.clr) begin
      m_q.delete();
      e.ready = 1'b0;
      e.count = '0;
      e.full  = 1'b0;
    end else if (s.rdy) begin
      n_before = m_q.size();
      sel = -1;
      for (int i = 0; i < m_q.size(); i++) begin
        if (sel < 0 && !m_q[i].p1 && !m_q[i].p2) sel = i;
      end
      if (sel >= 0 && !s.stall) begin
        e.ready = 1'b1;
        e.rob   = m_q[sel].rob;
        e.op    = m_q[sel].op;
        e.rs1   = m_q[sel].v1;
        e.rs2   = m_q[sel].v2;
        e.imm   = m_q[sel].imm;
        e.pc    = m_q[sel].pc;
        m_q.delete(sel);
      end else begin
        e.ready = 1'b0;
      end
      for (int i = 0; i < m_q.size(); i++) begin
        if (m_q[i].p1) begin
          k = cdb_hit(s, m_q[i].d1);
          if (k >= 0) begin m_q[i].v1 = s.cres[k*DATA_W +: DATA_W]; m_q[i].p1 = 1'b0; end
        end
        if (m_q[i].p2) begin
          k = cdb_hit(s, m_q[i].d2);
          if (k >= 0) begin m_q[i].v2 = s.cres[k*DATA_W +: DATA_W]; m_q[i].p2 = 1'b0; end
        end
      end
      if (s.iv && n_before < RS_DEPTH) begin
        n.rob = s.rob; n.op = s.op; n.imm = s.imm; n.pc = s.pc;
        n.d1 = s.d1; n.d2 = s.d2;
        k = cdb_hit(s, s.d1);
        n.p1 = s.b1 && (k < 0);
        n.v1 = (s.b1 && k >= 0) ? s.cres[k*DATA_W +: DATA_W] : s.v1;
        k = cdb_hit(s, s.d2);
        n.p2 = s.b2 && (k < 0);
        n.v2 = (s.b2 && k >= 0) ? s.cres[k*DATA_W +: DATA_W] : s.v2;
        m_q.push_back(n);
      end
      e.count = CNT_W'(m_q.size());
      e.full  = (m_q.size() == RS_DEPTH);
    end
    m_last = e;
    sb_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rst_n                = ~s.rst;
    bus.rdy_in           = s.rdy;
    bus.clr_in           = s.clr;
    bus.issue_valid      = s.iv;
    bus.issue_rob_index  = s.rob;
    bus.issue_op         = s.op;
    bus.issue_imm        = s.imm;
    bus.issue_PC         = s.pc;
    bus.issue_rs1_val    = s.v1;
    bus.issue_rs1_busy   = s.b1;
    bus.issue_rs1_depend = s.d1;
    bus.issue_rs2_val    = s.v2;
    bus.issue_rs2_busy   = s.b2;
    bus.issue_rs2_depend = s.d2;
    bus.cdb_valid        = s.cv;
    bus.cdb_rob_index    = s.cidx;
    bus.cdb_result       = s.cres;
    bus.alu_stall_in     = s.stall;
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    #1;
    apply(s);
    model_step(s);
    n_vec++;
  endtask

  function automatic stim_t s_idle();
    stim_t s;
    s     = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_issue(input int rob, input int v1, input bit b1, input int d1,
                                    input int v2, input bit b2, input int d2);
    stim_t s;
    s     = s_idle();
    s.iv  = 1'b1;
    s.rob = ROB_IDX_W'(rob);
    s.op  = OP_W'(rob + 1);
    s.imm = DATA_W'(32'h100 + rob);
    s.pc  = ADDR_W'(32'h8000 + 4 * rob);
    s.v1  = DATA_W'(v1); s.b1 = b1; s.d1 = ROB_IDX_W'(d1);
    s.v2  = DATA_W'(v2); s.b2 = b2; s.d2 = ROB_IDX_W'(d2);
    return s;
  endfunction

  // Monitor: one expectation per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("idle_ready", 64'(bus.rs_to_alu_ready), 64'(1'b0));
      end else begin
        e = sb_q.pop_front();
        chk("ready", 64'(bus.rs_to_alu_ready), 64'(e.ready));
        chk("count", 64'(bus.rs_count), 64'(e.count));
        chk("full",  64'(bus.rs_full), 64'(e.full));
        chk("rob",   64'(bus.rs_to_alu_rob_index), 64'(e.rob));
        chk("op",    64'(bus.rs_to_alu_op), 64'(e.op));
        chk("rs1",   64'(bus.rs_to_alu_rs1), 64'(e.rs1));
        chk("rs2",   64'(bus.rs_to_alu_rs2), 64'(e.rs2));
        chk("imm",   64'(bus.rs_to_alu_imm), 64'(e.imm));
        chk("pc",    64'(bus.rs_to_alu_PC), 64'(e.pc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver: directed scenarios then randomized traffic.
  initial begin
    stim_t s;
    int    c0;
    m_last = '0;
    s = s_idle(); s.rst = 1'b1;
    apply(s);
    step(s); step(s);
    step(s_idle());

    // Ready issue dispatches one cycle later, then a single pulse.
    step(s_issue(3, 32'h10, 1'b0, 0, 32'h20, 1'b0, 0));
    step(s_idle()); step(s_idle());

    // Same-cycle CDB bypass on channel 1.
    s = s_issue(5, 32'h0, 1'b1, 2, 32'h7, 1'b0, 0);
    s.cv = 2'b10; s.cidx = {4'd2, 4'd0}; s.cres = {32'hDEAD, 32'h0};
    step(s);
    step(s_idle()); step(s_idle());

    // Age ordering with a late wakeup on channel 0.
    step(s_issue(1, 32'h0, 1'b1, 7, 32'h11, 1'b0, 0));
    step(s_issue(2, 32'h22, 1'b0, 0, 32'h23, 1'b0, 0));
    step(s_issue(3, 32'h33, 1'b0, 0, 32'h34, 1'b0, 0));
    step(s_idle());
    s = s_idle(); s.cv = 2'b01; s.cidx = {4'd0, 4'd7}; s.cres = {32'h0, 32'h5};
    step(s);
    step(s_idle()); step(s_idle());

    // Fill all entries, overflow attempt, then flush.
    for (int i = 0; i < RS_DEPTH + 1; i++) step(s_issue(i % 16, i, 1'b1, 9, i, 1'b1, 9));
    step(s_idle());
    s = s_idle(); s.clr = 1'b1;
    step(s);
    step(s_idle()); step(s_idle());

    // ALU stall holds two ready entries; release dispatches oldest first.
    s = s_issue(10, 32'hA0, 1'b0, 0, 32'hA1, 1'b0, 0); s.stall = 1'b1; step(s);
    s = s_issue(11, 32'hB0, 1'b0, 0, 32'hB1, 1'b0, 0); s.stall = 1'b1; step(s);
    s = s_idle(); s.stall = 1'b1; step(s); step(s);
    step(s_idle()); step(s_idle()); step(s_idle());

    // Asynchronous reset with five busy entries.
    for (int i = 0; i < 5; i++) step(s_issue(i, i, 1'b1, 9, i, 1'b0, 0));
    s = s_idle(); s.rst = 1'b1;
    step(s);
    #1;
    chk("async_rst_count", 64'(bus.rs_count), 64'(0));
    chk("async_rst_ready", 64'(bus.rs_to_alu_ready), 64'(0));
    step(s);
    step(s_idle()); step(s_idle());

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      s = s_issue(int'($urandom_range(0, 15)), int'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));
      s.iv    = ($urandom_range(0, 99) < 55);
      s.op    = OP_W'($urandom_range(0, 63));
      s.imm   = $urandom;
      s.pc    = $urandom;
      s.cv[0] = ($urandom_range(0, 99) < 35);
      s.cv[1] = ($urandom_range(0, 99) < 35);
      c0      = int'($urandom_range(0, 15));
      s.cidx  = {ROB_IDX_W'((c0 + int'($urandom_range(1, 15))) % 16), ROB_IDX_W'(c0)};
      s.cres  = {$urandom, $urandom};
      s.stall = ($urandom_range(0, 99) < 25);
      s.clr   = ($urandom_range(0, 99) < 2);
      s.rdy   = ($urandom_range(0, 99) >= 8);
      step(s);
    end
    step(s_idle()); step(s_idle());
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
